// File: rtl/cordic_stream_ctrl.sv
// Valid/ready wrapper around a fixed-latency, handshake-free CORDIC pipeline.
// Credits bound accepts to FIFO space, so captured results are never dropped.
module cordic_stream_ctrl #(
    parameter int unsigned N_ITERATION = 12,
    parameter int unsigned BITS        = 33,
    parameter int unsigned TAG_BITS    = 4,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BITS-1:0]     s_x,
    input  logic [BITS-1:0]     s_y,
    input  logic [BITS-1:0]     s_z,
    input  logic [1:0]          s_mode,
    input  logic                s_rot_en,
    input  logic [TAG_BITS-1:0] s_tag,
    output logic [BITS-1:0]     c_x,
    output logic [BITS-1:0]     c_y,
    output logic [BITS-1:0]     c_z,
    output logic [1:0]          c_mode,
    output logic                c_rot_en,
    input  logic [BITS-1:0]     c_ox,
    input  logic [BITS-1:0]     c_oy,
    input  logic [BITS-1:0]     c_oz,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [BITS-1:0]     m_x,
    output logic [BITS-1:0]     m_y,
    output logic [BITS-1:0]     m_z,
    output logic [TAG_BITS-1:0] m_tag,
    output logic                m_err
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = 3 * BITS + TAG_BITS + 1;

    logic                accept;
    logic                pop;
    logic                illegal_mode;
    logic                empty;
    logic [PW:0]         credits_q, credits_d;
    logic [N_ITERATION:0] vld_q;
    logic [N_ITERATION:0] err_q;
    logic [TAG_BITS-1:0] tag_q [N_ITERATION+1];
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [PW:0]         wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]       head;

    assign illegal_mode = (s_mode == 2'b10);
    assign accept       = s_valid & s_ready;
    assign pop          = m_valid & m_ready;

    // Illegal mode is steered to linear so the core never carries an undefined mode.
    assign c_x      = s_x;
    assign c_y      = s_y;
    assign c_z      = s_z;
    assign c_mode   = illegal_mode ? 2'b00 : s_mode;
    assign c_rot_en = s_rot_en;

    assign s_ready = (credits_q != '0);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign m_valid = !empty;
    assign head    = mem_q[rd_ptr_q[PW-1:0]];
    assign {m_x, m_y, m_z, m_tag, m_err} = head;

    always_comb begin
        credits_d = credits_q;
        unique case ({accept, pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            credits_q <= (PW + 1)'(FIFO_DEPTH);
            vld_q     <= '0;
            err_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int j = 0; j <= int'(N_ITERATION); j++) begin
                tag_q[j] <= '0;
            end
            // Clearing every entry keeps the show-ahead head at zero after reset.
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            credits_q <= credits_d;
            vld_q     <= {vld_q[N_ITERATION-1:0], accept};
            err_q     <= {err_q[N_ITERATION-1:0], illegal_mode};
            tag_q[0]  <= s_tag;
            for (int j = 1; j <= int'(N_ITERATION); j++) begin
                tag_q[j] <= tag_q[j-1];
            end
            if (vld_q[N_ITERATION]) begin
                mem_q[wr_ptr_q[PW-1:0]] <= {c_ox, c_oy, c_oz,
                                            tag_q[N_ITERATION], err_q[N_ITERATION]};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cordic_stream_ctrl.sv
// Bench for cordic_stream_ctrl: ideal-math core stub plus a queue model of
// accepted-but-unpopped requests that predicts s_ready, m_valid and m_* every cycle.
module tb_cordic_stream_ctrl;

    localparam int N     = 12;
    localparam int LAT   = N + 1;
    localparam int BITS  = 33;
    localparam int TB    = 4;
    localparam int DEPTH = 16;
    localparam real ONE  = 1073741824.0;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid, s_ready, s_rot_en;
    logic [BITS-1:0] s_x, s_y, s_z;
    logic [1:0]      s_mode;
    logic [TB-1:0]   s_tag;
    logic [BITS-1:0] c_x, c_y, c_z, c_ox, c_oy, c_oz;
    logic [1:0]      c_mode;
    logic            c_rot_en;
    logic            m_valid, m_ready, m_err;
    logic [BITS-1:0] m_x, m_y, m_z;
    logic [TB-1:0]   m_tag;

    always #5 clk = ~clk;

    cordic_stream_ctrl #(
        .N_ITERATION(N), .BITS(BITS), .TAG_BITS(TB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_mode(s_mode), .s_rot_en(s_rot_en), .s_tag(s_tag),
        .c_x(c_x), .c_y(c_y), .c_z(c_z), .c_mode(c_mode), .c_rot_en(c_rot_en),
        .c_ox(c_ox), .c_oy(c_oy), .c_oz(c_oz),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_x(m_x), .m_y(m_y), .m_z(m_z), .m_tag(m_tag), .m_err(m_err)
    );

    // Stand-in core: ideal rotation for circular/linear rotation, arbitrary mix otherwise.
    function automatic logic [3*BITS-1:0] core_fn(input logic signed [BITS-1:0] x,
                                                  input logic signed [BITS-1:0] y,
                                                  input logic signed [BITS-1:0] z,
                                                  input logic [1:0] mode, input logic rot);
        real    rx, ry, rz;
        longint tx, ty;
        logic [BITS-1:0] ox, oy, oz;
        if (mode == 2'b01 && rot) begin
            rx = real'(x) / ONE;
            ry = real'(y) / ONE;
            rz = real'(z) / ONE;
            tx = longint'((rx * $cos(rz) - ry * $sin(rz)) * ONE);
            ty = longint'((ry * $cos(rz) + rx * $sin(rz)) * ONE);
            ox = tx[BITS-1:0];
            oy = ty[BITS-1:0];
            oz = '0;
        end else if (mode == 2'b00 && rot) begin
            ty = longint'(y) + ((longint'(x) * longint'(z)) >>> 30);
            ox = x;
            oy = ty[BITS-1:0];
            oz = '0;
        end else begin
            ox = x ^ y;
            oy = y + z;
            oz = z - x;
        end
        return {ox, oy, oz};
    endfunction

    logic [BITS-1:0] px [LAT];
    logic [BITS-1:0] py [LAT];
    logic [BITS-1:0] pz [LAT];
    logic [1:0]      pm [LAT];
    logic            pr [LAT];

    always @(posedge clk) begin
        px[0] <= c_x; py[0] <= c_y; pz[0] <= c_z; pm[0] <= c_mode; pr[0] <= c_rot_en;
        for (int j = 1; j < LAT; j++) begin
            px[j] <= px[j-1]; py[j] <= py[j-1]; pz[j] <= pz[j-1];
            pm[j] <= pm[j-1]; pr[j] <= pr[j-1];
        end
    end

    assign {c_ox, c_oy, c_oz} = core_fn(px[LAT-1], py[LAT-1], pz[LAT-1], pm[LAT-1], pr[LAT-1]);

    typedef struct {
        logic [3*BITS-1:0] data;
        logic [TB-1:0]     tag;
        logic              err;
        int                k;
    } exp_t;

    exp_t            sb[$];
    int              n_chk = 0, n_pass = 0;
    int              edge_cnt = 0, edge_at_sample = 0;
    bit              chk_en = 0, mv_seen = 0, stream_on = 0;
    int              acc_dut = 0, pop_dut = 0, err_pops = 0, stream_idx = 0;
    logic [TB-1:0]   err_tag;
    logic [BITS-1:0] smp_x, smp_y;
    logic [TB-1:0]   smp_tag;
    logic            smp_err;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit near(input logic [BITS-1:0] v, input longint want, input longint tol);
        longint d;
        d = longint'($signed(v)) - want;
        return (d <= tol) && (d >= -tol);
    endfunction

    // One clock: sample/check before the edge, update the model after it.
    task automatic tick();
        bit   exp_rdy, exp_mv, acc, pop;
        exp_t e;
        #1;
        exp_rdy        = (sb.size() < DEPTH);
        exp_mv         = (sb.size() > 0) && (edge_cnt >= sb[0].k + LAT);
        mv_seen        = m_valid;
        edge_at_sample = edge_cnt;
        smp_x = m_x; smp_y = m_y; smp_tag = m_tag; smp_err = m_err;
        if (chk_en) begin
            check("s_ready", s_ready, exp_rdy);
            check("m_valid", m_valid, exp_mv);
            check("c_mode", c_mode, (s_mode == 2'b10) ? 2'b00 : s_mode);
            check("c_pass", {c_x, c_y, c_z, c_rot_en}, {s_x, s_y, s_z, s_rot_en});
            if (exp_mv) begin
                check("m_data", {m_x, m_y, m_z}, sb[0].data);
                check("m_tag", m_tag, sb[0].tag);
                check("m_err", m_err, sb[0].err);
            end
        end
        acc = s_valid && exp_rdy && !rst;
        pop = m_ready && exp_mv && !rst;
        if (s_valid && s_ready) acc_dut++;
        if (m_valid && m_ready) begin
            pop_dut++;
            if (m_err) begin
                err_pops++;
                err_tag = m_tag;
            end
        end
        if (pop && stream_on) begin
            check("stream_y", near(m_y, longint'(stream_idx) <<< 24, 1 <<< 19), 1'b1);
            stream_idx++;
        end
        e.data = core_fn(s_x, s_y, s_z, (s_mode == 2'b10) ? 2'b00 : s_mode, s_rot_en);
        e.tag  = s_tag;
        e.err  = (s_mode == 2'b10);
        @(posedge clk);
        edge_cnt++;
        e.k = edge_cnt;
        if (rst) sb.delete();
        else begin
            if (pop) void'(sb.pop_front());
            if (acc) sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [BITS-1:0] x, input logic [BITS-1:0] y,
                         input logic [BITS-1:0] z, input logic [1:0] mode, input bit rot,
                         input logic [TB-1:0] tag);
        s_valid = v; s_x = x; s_y = y; s_z = z; s_mode = mode; s_rot_en = rot; s_tag = tag;
    endtask

    task automatic drain();
        s_valid = 0;
        m_ready = 1;
        for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
        tick();
        check("drain_mvalid", m_valid, 1'b0);
    endtask

    task automatic measure_single(input string tag);
        int k;
        m_ready = 1;
        drive(1, 33'h0_4000_0000, '0, 33'h0_3243_F6A8, 2'b01, 1, 4'd5);
        tick();
        k = edge_cnt;
        s_valid = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (mv_seen) break;
        end
        check(tag, edge_at_sample - k, LAT);
        check({tag, "_x"}, near(smp_x, 759250125, 1 <<< 20), 1'b1);
        check({tag, "_y"}, near(smp_y, 759250125, 1 <<< 20), 1'b1);
        check({tag, "_tag"}, smp_tag, 4'd5);
        check({tag, "_err"}, smp_err, 1'b0);
    endtask

    function automatic logic [BITS-1:0] rnd_q();
        logic [30:0] r;
        r = 31'($urandom);
        return {{2{r[30]}}, r};
    endfunction

    initial begin
        int base;
        logic [2:0] sel;
        logic [1:0] md;
        rst = 1; m_ready = 0;
        drive(0, '0, '0, '0, 2'b00, 0, '0);
        tick();
        tick();
        rst = 0;
        check("rst_head", {m_x, m_y, m_z, m_tag, m_err}, '0);
        check("rst_mvalid", m_valid, 1'b0);
        check("rst_sready", s_ready, 1'b1);
        chk_en = 1;

        measure_single("lat_single");

        // Back-to-back linear rotations; the per-cycle model flags any m_valid gap.
        m_ready = 1; stream_on = 1; stream_idx = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1, 33'h0_4000_0000, '0, BITS'(i) << 24, 2'b00, 1, TB'(i % 16));
            tick();
        end
        drain();
        stream_on = 0;
        check("stream_n", stream_idx, 40);

        m_ready = 0; acc_dut = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1, rnd_q(), rnd_q(), rnd_q(), 2'b00, 1, TB'(i));
            tick();
        end
        check("bp_accepts", acc_dut, 16);
        check("bp_sready", s_ready, 1'b0);
        base = pop_dut; acc_dut = 0;
        m_ready = 1;
        tick();
        m_ready = 0;
        for (int i = 0; i < 5; i++) tick();
        check("bp_pops", pop_dut - base, 1);
        check("bp_extra", acc_dut, 1);
        drain();

        err_pops = 0;
        m_ready = 1;
        drive(1, rnd_q(), rnd_q(), rnd_q(), 2'b00, 1, 4'd2); tick();
        drive(1, rnd_q(), rnd_q(), rnd_q(), 2'b10, 0, 4'd3); tick();
        drive(1, rnd_q(), rnd_q(), rnd_q(), 2'b00, 1, 4'd4); tick();
        drain();
        check("err_pops", err_pops, 1);
        check("err_tag", err_tag, 4'd3);

        base = pop_dut; acc_dut = 0;
        for (int g = 0; g < 20000 && acc_dut < 1000; g++) begin
            sel = 3'($urandom);
            unique case (sel)
                3'd0, 3'd1:       md = 2'b11;
                3'd2, 3'd3:       md = 2'b00;
                3'd4, 3'd5, 3'd6: md = 2'b01;
                default:          md = 2'b10;
            endcase
            drive(1'($urandom), rnd_q(), rnd_q(), rnd_q(), md, 1'($urandom), TB'($urandom));
            if (acc_dut == 999) s_valid = s_valid & 1'b1;
            m_ready = ($urandom_range(0, 9) < 3);
            tick();
        end
        drain();
        check("rand_accepts", acc_dut, 1000);
        check("rand_pops", pop_dut - base, acc_dut);

        m_ready = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, rnd_q(), rnd_q(), rnd_q(), 2'b01, 1, TB'(i));
            tick();
        end
        s_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        check("mid_rst_head", {m_x, m_y, m_z, m_tag, m_err}, '0);
        check("mid_rst_mvalid", m_valid, 1'b0);
        check("mid_rst_sready", s_ready, 1'b1);
        m_ready = 1;
        for (int i = 0; i < LAT + 6; i++) tick();
        measure_single("lat_after_rst");
        m_ready = 0; acc_dut = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, rnd_q(), rnd_q(), rnd_q(), 2'b00, 1, TB'(i));
            tick();
        end
        check("rst_credits", acc_dut, 16);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
